// File: rtl/tds_link_pkg.sv
// Shared types and width helpers for the TDS lane training controller.
package tds_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RST       = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_LINKED    = 3'd3,
      ST_LOSS      = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int loss_cnt_width(input int loss_filter);
      return cnt_width(loss_filter);
   endfunction

   // RST and WAIT_LOCK share one counter, so it must hold the larger span.
   function automatic int rst_cnt_width(input int rst_cycles, input int lock_timeout);
      return (cnt_width(rst_cycles) > cnt_width(lock_timeout)) ?
             cnt_width(rst_cycles) : cnt_width(lock_timeout);
   endfunction

endpackage

// File: rtl/tds_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module tds_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (srst || clr)
         cnt_reg <= '0;
      else if (inc && (cnt_reg != {WIDTH{1'b1}}))
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/tds_link_train_ctrl.sv
// Reset/lock sequencer for one strip/pad decoder pair on a GTP lane.
// Optional link statistics outputs are built when LINK_STAT_EN is defined.
module tds_link_train_ctrl
   import tds_link_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int LOSS_FILTER  = 8,
   parameter int MAX_RETRY    = 7
) (
   input  logic        clk160,
   input  logic        reset,
   input  logic        enable,
   input  logic        strip_en,
   input  logic        pad_en,
   input  logic        strip_linked,
   input  logic        pad_linked,
   input  logic        retrain,
   output logic        decoder_reset,
   output logic        lane_up,
   output logic        lane_fail,
   output logic [2:0]  state,
   output logic [3:0]  retry_cnt,
   output logic [15:0] lock_time
`ifdef LINK_STAT_EN
   ,output logic [15:0] loss_events
   ,output logic [0:0]  strip_drop_last
`endif
);

   localparam int WAIT_W = rst_cnt_width(RST_CYCLES, LOCK_TIMEOUT);
   localparam int LOSS_W = loss_cnt_width(LOSS_FILTER);
   localparam logic [WAIT_W-1:0] RST_LAST     = WAIT_W'(RST_CYCLES - 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_FILTER - 1);
   localparam logic [3:0]        RETRY_LIMIT  = 4'(MAX_RETRY);

   state_t             state_reg, state_next;
   logic [3:0]         retry_cnt_reg, retry_cnt_next, retry_inc;
   logic [15:0]        lock_time_reg, lock_time_next;
   logic               decoder_reset_reg, lane_up_reg, lane_fail_reg;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [LOSS_W-1:0]  loss_cnt;
   logic               required_ok, restart, wait_clr, wait_inc, loss_clr, loss_declared;

   assign required_ok = (strip_linked | ~strip_en) & (pad_linked | ~pad_en);
   assign restart     = retrain && enable && (state_reg != ST_IDLE);
   assign retry_inc   = (retry_cnt_reg == 4'hF) ? 4'hF : retry_cnt_reg + 4'd1;

   // Restart from zero on every state entry, including a retrain that re-enters RST.
   assign wait_clr = (state_next != state_reg) || restart;
   assign wait_inc = (state_reg == ST_RST) || (state_reg == ST_WAIT_LOCK);
   assign loss_clr = (state_reg != ST_LINKED) || required_ok;
   assign loss_declared = (state_reg == ST_LINKED) && (state_next == ST_LOSS);

   tds_sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
      .clk(clk160), .srst(reset), .clr(wait_clr), .inc(wait_inc), .cnt(wait_cnt)
   );

   tds_sat_counter #(.WIDTH(LOSS_W)) u_loss_cnt (
      .clk(clk160), .srst(reset), .clr(loss_clr), .inc(~required_ok), .cnt(loss_cnt)
   );

   always_comb begin
      state_next     = state_reg;
      retry_cnt_next = retry_cnt_reg;
      lock_time_next = lock_time_reg;
      case (state_reg)
         ST_IDLE:      if (enable) state_next = ST_RST;
         ST_RST:       if (wait_cnt == RST_LAST) state_next = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (required_ok) begin
               state_next     = ST_LINKED;
               lock_time_next = 16'(wait_cnt);
            end else if (wait_cnt == TIMEOUT_LAST) begin
               retry_cnt_next = retry_inc;
               state_next     = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RST;
            end
         end
         ST_LINKED:    if (!required_ok && (loss_cnt == LOSS_LAST)) state_next = ST_LOSS;
         ST_LOSS: begin
            retry_cnt_next = 4'd0;
            state_next     = ST_RST;
         end
         ST_FAIL:      state_next = ST_FAIL;
         default:      state_next = ST_IDLE;
      endcase
      if (restart) begin
         state_next     = ST_RST;
         retry_cnt_next = 4'd0;
         lock_time_next = lock_time_reg;
      end
      // Disabling the lane overrides everything and leaves the bookkeeping untouched.
      if (!enable) begin
         state_next     = ST_IDLE;
         retry_cnt_next = retry_cnt_reg;
         lock_time_next = lock_time_reg;
      end
   end

   always_ff @(posedge clk160) begin
      if (reset) begin
         state_reg         <= ST_IDLE;
         retry_cnt_reg     <= 4'd0;
         lock_time_reg     <= 16'd0;
         decoder_reset_reg <= 1'b1;
         lane_up_reg       <= 1'b0;
         lane_fail_reg     <= 1'b0;
      end else begin
         state_reg         <= state_next;
         retry_cnt_reg     <= retry_cnt_next;
         lock_time_reg     <= lock_time_next;
         decoder_reset_reg <= (state_reg == ST_IDLE) || (state_reg == ST_RST);
         lane_up_reg       <= (state_reg == ST_LINKED);
         lane_fail_reg     <= (state_reg == ST_FAIL);
      end
   end

   assign state         = state_reg;
   assign retry_cnt     = retry_cnt_reg;
   assign lock_time     = lock_time_reg;
   assign decoder_reset = decoder_reset_reg;
   assign lane_up       = lane_up_reg;
   assign lane_fail     = lane_fail_reg;

`ifdef LINK_STAT_EN
   logic strip_drop_last_reg;

   tds_sat_counter #(.WIDTH(16)) u_loss_events (
      .clk(clk160), .srst(reset), .clr(1'b0), .inc(loss_declared), .cnt(loss_events)
   );

   // Strip is blamed first when both required channels are down.
   always_ff @(posedge clk160) begin
      if (reset)
         strip_drop_last_reg <= 1'b0;
      else if (loss_declared)
         strip_drop_last_reg <= strip_en && !strip_linked;
   end

   assign strip_drop_last = strip_drop_last_reg;
`else
   logic unused_loss_declared;
   assign unused_loss_declared = loss_declared;
`endif

endmodule

// File: doc/tds_link_train_ctrl.md
Name: tds_link_train_ctrl

Overview:
Sequencer for one strip/pad decoder pair on a GTP lane. It pulses the decoder resets and waits for the enabled channels to report linked. It filters link drops, retries with a bounded retry count, and reports lane status to readout. It sits beside the strip/pad decoder instance in the 160 MHz readout domain.

Parameters:
RST_CYCLES, 16, cycles decoder reset is held high (range 1..255)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry (range 2..65535)
LOSS_FILTER, 8, consecutive cycles of a required linked flag low before loss is declared (range 1..255)
MAX_RETRY, 7, failed lock attempts before FAIL (range 1..15)

Ports:
clk160  input  1  readout clock; the only clock
reset  input  1  synchronous, active-high
enable  input  1  level; low forces IDLE
strip_en  input  1  strip channel required for lock
pad_en  input  1  pad channel required for lock
strip_linked  input  1  from strip checker; already in clk160 domain
pad_linked  input  1  from pad checker; already in clk160 domain
retrain  input  1  single-cycle request to restart training
decoder_reset  output  1  drives decoder reset_160M and, through the existing CDC, SYSTEM_RESET
lane_up  output  1  all required channels linked
lane_fail  output  1  retries exhausted
state  output  3  FSM state encoding
retry_cnt  output  4  failed attempts in the current training run
lock_time  output  16  cycles WAIT_LOCK took in the last successful lock

Behaviour:
- Reset: state=IDLE. decoder_reset=1, lane_up=0, lane_fail=0, retry_cnt=0, lock_time=0. All counters are cleared.
- required_ok = (strip_linked | ~strip_en) & (pad_linked | ~pad_en).
- If strip_en=pad_en=0, required_ok is always 1. Lane comes up after one reset pulse plus one WAIT_LOCK cycle.
- State encoding: IDLE=0, RST=1, WAIT_LOCK=2, LINKED=3, LOSS=4, FAIL=5.
- IDLE: decoder_reset=1. Goes to RST when enable=1.
- RST: decoder_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK. The wait counter restarts at 0 on entry.
- WAIT_LOCK: decoder_reset=0. The wait counter increments every cycle.
  - required_ok=1: go to LINKED. lock_time <= counter value.
  - Counter reaches LOCK_TIMEOUT-1 with required_ok=0: retry_cnt++. Then FAIL if the new retry_cnt==MAX_RETRY, else RST.
  - Lock takes priority over timeout when both occur in the same cycle.
- LINKED: lane_up=1. The loss counter counts consecutive cycles with required_ok=0 and clears on any cycle with required_ok=1.
  - When it reaches LOSS_FILTER: go to LOSS, lane_up=0 from the next cycle.
  - LOSS_FILTER-1 low cycles followed by one high cycle does not cause loss.
- LOSS: one cycle. retry_cnt cleared to 0, then RST.
- FAIL: lane_fail=1, decoder_reset=0. Held until retrain or reset.
- retrain (any state except IDLE): next state RST. retry_cnt=0, lane_fail=0, lane_up=0. It wins over every other transition in the same cycle.
- enable=0: next state IDLE from any state. It has priority over retrain.
- Registered outputs: all outputs reflect the current state, with no combinational path from inputs.
- decoder_reset rises in the cycle after the state enters IDLE or RST.
- Counter widths: sized with $clog2 of their parameter. Counters saturate and never wrap.
- Reset asserted mid-training: the next cycle matches the post-reset values exactly.

Optional Feature:
Macro: LINK_STAT_EN.
- Defined: adds output loss_events [15:0]. It counts LINKED->LOSS transitions, saturates at 16'hFFFF, and is cleared only by reset.
- Also adds output strip_drop_last [0:0]. It records whether strip (1) or pad (0) was the failing required channel at loss declaration, with strip checked first.
- Not defined: neither port exists and no logic is generated.

Decomposition:
- Package tds_link_pkg: state enum (3-bit, values as above) and the LOSS_FILTER/RST_CYCLES width helper functions.
- One natural sub-module: tds_sat_counter (parameterised width, clear, increment, saturate). Used for the wait, loss and stat counters.

Test Plan:
1. Reset, enable=1, both linked tied high: decoder_reset high 16 cycles after leaving IDLE; lane_up=1 two cycles later; lock_time=0.
2. Lock at 100: pad_en=0, strip_linked rises 100 cycles into WAIT_LOCK -> lock_time=100, lane_up=1, pad_linked ignored.
3. Never lock: linked flags held 0 -> 7 timeouts of 4096 cycles each with RST between; lane_fail=1; retry_cnt=7; state=5 held.
4. Glitch filtering: in LINKED, strip_linked low 7 cycles then high -> stays LINKED. Low 8 cycles -> LOSS for one cycle, then RST, retry_cnt=0.
5. Simultaneous events:
   - retrain in the same cycle as WAIT_LOCK timeout -> RST with retry_cnt=0.
   - enable=0 with retrain -> IDLE.
6. Mid-operation reset in WAIT_LOCK at count 2000 -> outputs equal reset values next cycle. With LINK_STAT_EN, 3 losses -> loss_events=3.
